// File: rtl/servo_timing_pkg.sv
// Timing constants shared by every motor channel and the power modulator.
package servo_timing_pkg;

    // Counter and frame-index widths.
    localparam int unsigned CNT_W   = 21;
    localparam int unsigned STATE_W = 5;

    // Default timing for a 100 MHz system clock.
    localparam int unsigned SERVO_CLK_RATE      = 100_000_000;
    localparam int unsigned SERVO_PERIOD_CLKS   = 2_000_000;  // 20 ms frame
    localparam int unsigned SERVO_FRAMES        = 24;
    localparam int unsigned SERVO_MIN_PULSE     = 100_000;    // 1 ms, full forward
    localparam int unsigned SERVO_MAX_PULSE     = 200_000;    // 2 ms, full reverse
    localparam int unsigned SERVO_NEUTRAL_PULSE = 150_000;    // 1.5 ms, idle

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [STATE_W-1:0] frame_idx_t;

endpackage

// File: rtl/servo_pulse_clamp.sv
// Limits a requested pulse width to the legal servo range and reports
// whether the request had to be limited.
module servo_pulse_clamp
    import servo_timing_pkg::*;
#(
    parameter int unsigned MIN_PULSE = SERVO_MIN_PULSE,
    parameter int unsigned MAX_PULSE = SERVO_MAX_PULSE
) (
    input  logic [CNT_W-1:0] pulse,
    output logic [CNT_W-1:0] eff,
    output logic             clamped
);

    localparam cnt_t LO = cnt_t'(MIN_PULSE);
    localparam cnt_t HI = cnt_t'(MAX_PULSE);

    function automatic cnt_t saturate(input cnt_t p);
        if (p < LO) begin
            return LO;
        end else if (p > HI) begin
            return HI;
        end else begin
            return p;
        end
    endfunction

    assign eff     = saturate(pulse);
    assign clamped = (pulse < LO) || (pulse > HI);

endmodule

// File: rtl/servo_frame_pwm.sv
// Servo/ESC output stage: one pulse per frame, width latched at the frame
// boundary, plus the frame index that steers the upstream modulator.
module servo_frame_pwm
    import servo_timing_pkg::*;
#(
    parameter int unsigned CLK_RATE      = SERVO_CLK_RATE,
    parameter int unsigned PERIOD_CLKS   = SERVO_PERIOD_CLKS,
    parameter int unsigned FRAMES        = SERVO_FRAMES,
    parameter int unsigned MIN_PULSE     = SERVO_MIN_PULSE,
    parameter int unsigned MAX_PULSE     = SERVO_MAX_PULSE,
    parameter int unsigned NEUTRAL_PULSE = SERVO_NEUTRAL_PULSE
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Enable,
    input  logic [CNT_W-1:0]   Pulse,
    output logic [STATE_W-1:0] State,
    output logic               PwmOut,
    output logic               FrameStart,
    output logic [CNT_W-1:0]   Width,
    output logic               ClampFlag
);

    // The pulse must end before the frame index advances, and the counter
    // must hold a full frame.
    if (CLK_RATE == 0 || PERIOD_CLKS > (1 << CNT_W) || PERIOD_CLKS < 2 ||
        MAX_PULSE >= PERIOD_CLKS / 2 || MIN_PULSE > MAX_PULSE ||
        FRAMES == 0 || FRAMES > (1 << STATE_W)) begin : g_cfg_err
        $error("servo_frame_pwm: inconsistent timing parameters");
    end

    localparam cnt_t       LAST_CNT   = cnt_t'(PERIOD_CLKS - 1);
    localparam cnt_t       HALF_CNT   = cnt_t'(PERIOD_CLKS / 2);
    localparam cnt_t       NEUTRAL    = cnt_t'(NEUTRAL_PULSE);
    localparam frame_idx_t LAST_STATE = frame_idx_t'(FRAMES - 1);

    cnt_t cnt;
    cnt_t eff;
    cnt_t w;
    logic oor;
    logic at_start;
    logic at_half;

    servo_pulse_clamp #(
        .MIN_PULSE (MIN_PULSE),
        .MAX_PULSE (MAX_PULSE)
    ) u_clamp (
        .pulse   (Pulse),
        .eff     (eff),
        .clamped (oor)
    );

    // At the frame boundary the freshly clamped request takes effect at once.
    always_comb begin
        at_start = (cnt == '0);
        at_half  = (cnt == HALF_CNT);
        w        = at_start ? eff : Width;
    end

    // Frame counter, waveform, boundary strobe and frame index.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            State      <= '0;
            PwmOut     <= 1'b0;
            FrameStart <= 1'b0;
            Width      <= NEUTRAL;
            ClampFlag  <= 1'b0;
        end else if (!Enable) begin
            cnt        <= '0;
            PwmOut     <= 1'b0;
            FrameStart <= 1'b0;
        end else begin
            cnt        <= (cnt == LAST_CNT) ? '0 : cnt + cnt_t'(1);
            PwmOut     <= (cnt < w);
            FrameStart <= at_start;
            if (at_start) begin
                Width     <= eff;
                ClampFlag <= oor;
            end
            if (at_half) begin
                State <= (State == LAST_STATE) ? '0 : State + frame_idx_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_servo_frame_pwm.sv
// Self-checking bench for servo_frame_pwm with scaled-down frame timing.
module tb_servo_frame_pwm;

    localparam int P    = 200;
    localparam int NFR  = 24;
    localparam int MINP = 20;
    localparam int MAXP = 40;
    localparam int NEU  = 30;
    localparam int NV   = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [20:0] pulse;
    logic [4:0]  state;
    logic        pwm;
    logic        fs;
    logic [20:0] width;
    logic        cflag;

    servo_frame_pwm #(
        .CLK_RATE      (100_000_000),
        .PERIOD_CLKS   (P),
        .FRAMES        (NFR),
        .MIN_PULSE     (MINP),
        .MAX_PULSE     (MAXP),
        .NEUTRAL_PULSE (NEU)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .Enable     (en),
        .Pulse      (pulse),
        .State      (state),
        .PwmOut     (pwm),
        .FrameStart (fs),
        .Width      (width),
        .ClampFlag  (cflag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] pulse;
        logic [20:0] width;
        logic        flag;
        int          high;
    } vec_t;

    vec_t vecs[NV];
    vec_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fs_cyc = 0;
    bit sb_on = 0;

    // Monitor state
    bit          in_frame = 0;
    bit          prev_pwm = 0;
    int          hi = 0;
    int          rises = 0;
    int          start_cyc = 0;
    logic [20:0] fs_w;
    logic        fs_f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: measures each completed frame and compares it
    // with the expectation queued when its Pulse was driven.
    always @(posedge clk) begin
        #1;
        if (fs) last_fs_cyc = cyc;
        if (rst || !en || !sb_on) begin
            in_frame = 0;
        end else begin
            if (fs) begin
                if (in_frame) begin
                    chk("sb_nonempty", (sbq.size() > 0), 1);
                    if (sbq.size() > 0) begin
                        vec_t e;
                        e = sbq.pop_front();
                        chk("sb_width", fs_w, e.width);
                        chk("sb_flag", fs_f, e.flag);
                        chk("sb_high", hi, e.high);
                        chk("sb_rises", rises, 1);
                        chk("sb_period", cyc - start_cyc, P);
                    end
                end
                in_frame  = 1;
                hi        = 0;
                rises     = 0;
                prev_pwm  = 0;
                fs_w      = width;
                fs_f      = cflag;
                start_cyc = cyc;
            end
            if (in_frame) begin
                if (pwm && !prev_pwm) rises++;
                if (pwm) hi++;
                prev_pwm = pwm;
            end
        end
    end

    task automatic wait_fs();
        bit got;
        got = 0;
        for (int k = 0; k < P + 20; k++) begin
            @(negedge clk);
            if (fs) begin
                got = 1;
                break;
            end
        end
        chk("fs_seen", got, 1);
    endtask

    task automatic count_high(input int n, output int cnt_hi);
        cnt_hi = pwm ? 1 : 0;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            if (pwm) cnt_hi++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [4:0]  prev_state;
        logic [4:0]  held_state;
        bit          got;

        vecs[0] = '{21'd30,      21'd30, 1'b0, 30};
        vecs[1] = '{21'd5,       21'd20, 1'b1, 20};
        vecs[2] = '{21'd60,      21'd40, 1'b1, 40};
        vecs[3] = '{21'd20,      21'd20, 1'b0, 20};
        vecs[4] = '{21'd40,      21'd40, 1'b0, 40};
        vecs[5] = '{21'd0,       21'd20, 1'b1, 20};
        vecs[6] = '{21'd41,      21'd40, 1'b1, 40};
        vecs[7] = '{21'd19,      21'd20, 1'b1, 20};
        vecs[8] = '{21'd21,      21'd21, 1'b0, 21};
        vecs[9] = '{21'h1FFFFF,  21'd40, 1'b1, 40};

        // Reset with Enable already high: reset must win.
        rst   = 1'b1;
        en    = 1'b1;
        pulse = vecs[0].pulse;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm, 0);
        chk("rst_fs", fs, 0);
        chk("rst_state", state, 0);
        chk("rst_width", width, NEU);
        chk("rst_flag", cflag, 0);

        // Table-driven frames through the scoreboard.
        sbq.push_back(vecs[0]);
        sb_on = 1;
        rst   = 1'b0;
        @(negedge clk);
        chk("first_fs", fs, 1);
        chk("first_pwm", pwm, 1);
        for (int i = 1; i < NV; i++) begin
            if (i > 1) wait_fs();
            pulse = vecs[i].pulse;
            sbq.push_back(vecs[i]);
        end
        for (int k = 0; k < 3 * P && sbq.size() > 0; k++) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
        sb_on = 0;

        // Frame index sequence across 24 advances.
        pulse = 21'd30;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("seq_state0", state, 0);
        prev_state = state;
        for (int k = 1; k <= NFR; k++) begin
            got = 0;
            for (int t = 0; t < 2 * P; t++) begin
                @(negedge clk);
                if (state !== prev_state) begin
                    got = 1;
                    break;
                end
            end
            chk("seq_change", got, 1);
            chk("seq_value", state, k % NFR);
            chk("seq_delay", cyc - last_fs_cyc, P / 2);
            prev_state = state;
        end

        // Enable dropped mid-pulse, then restored.
        wait_fs();
        repeat (10) @(negedge clk);
        chk("dis_pre_pwm", pwm, 1);
        held_state = state;
        en = 1'b0;
        @(negedge clk);
        chk("dis_pwm", pwm, 0);
        chk("dis_fs", fs, 0);
        n = 0;
        repeat (150) begin
            @(negedge clk);
            if (pwm || fs) n++;
        end
        chk("dis_idle", n, 0);
        chk("dis_state", state, held_state);
        chk("dis_width", width, 30);
        en = 1'b1;
        @(negedge clk);
        chk("reen_fs", fs, 1);
        chk("reen_state", state, held_state);
        count_high(60, n);
        chk("reen_high", n, 30);

        // Reset in the middle of a clamped pulse.
        pulse = 21'd60;
        wait_fs();
        chk("pre_rst_width", width, 40);
        chk("pre_rst_flag", cflag, 1);
        chk("pre_rst_state", state, held_state + 5'd1);
        repeat (12) @(negedge clk);
        chk("pre_rst_pwm", pwm, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pwm", pwm, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_width", width, NEU);
        chk("mid_rst_flag", cflag, 0);
        chk("mid_rst_fs", fs, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fs", fs, 1);
        chk("post_rst_width", width, 40);
        chk("post_rst_flag", cflag, 1);
        count_high(60, n);
        chk("post_rst_high", n, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
